// File: rtl/ctrl_word_if.sv
// Control-word bundle between a sequencer FSM and the execution datapath,
// including the board read-back signals.
interface ctrl_word_if #(
   parameter int WIDTH = 16
);
   logic [7:0]       alu_op;
   logic [7:0]       muxes;
   logic [15:0]      regs_en;
   logic [WIDTH-1:0] imm;
   logic [3:0]       disp_sel;
   logic [WIDTH-1:0] disp_data;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] last_result;
   logic [4:0]       flags;
   logic             illegal_op;

   modport master (
      output alu_op, muxes, regs_en, imm, disp_sel,
      input  disp_data, result, last_result, flags, illegal_op
   );

   modport slave (
      input  alu_op, muxes, regs_en, imm, disp_sel,
      output disp_data, result, last_result, flags, illegal_op
   );
endinterface

// File: rtl/ctrl_word_datapath.sv
// Execution datapath for sequencer control words: 16-entry register file,
// ALU and {C,L,F,Z,N} status register, one word per clock.
module ctrl_word_datapath #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16
) (
   input  logic        clk,
   input  logic        reset,
   ctrl_word_if.slave  cw
);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_AND = 4'h1;
   localparam logic [3:0] OP_OR  = 4'h2;
   localparam logic [3:0] OP_XOR = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h5;
   localparam logic [3:0] OP_SUB = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hB;
   localparam logic [3:0] OP_MOV = 4'hD;

   localparam int FC = 4;
   localparam int FL = 3;
   localparam int FF = 2;
   localparam int FZ = 1;
   localparam int FN = 0;

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] last_q;
   logic [4:0]       flags_q;
   logic             illegal_q;

   logic [3:0]       code;
   logic             use_imm;
   logic             legal;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] res;
   logic [4:0]       flags_nxt;
   logic             does_write;

   // Register ops carry the opcode in [3:0]; immediate ops carry it in [7:4].
   // An X opcode fails every comparison and falls through to illegal.
   always_comb begin
      code    = OP_NOP;
      use_imm = 1'b0;
      legal   = 1'b1;
      if (cw.alu_op == 8'h00) begin
         code = OP_NOP;
      end else if (cw.alu_op[3:0] == 4'h0) begin
         code    = cw.alu_op[7:4];
         use_imm = 1'b1;
      end else if (cw.alu_op[7:4] == 4'h0) begin
         code = cw.alu_op[3:0];
      end else begin
         legal = 1'b0;
      end
      case (code)
         OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV: ;
         default: legal = 1'b0;
      endcase
   end

   assign op_a = regs[cw.muxes[7:4]];
   assign op_b = use_imm ? cw.imm : regs[cw.muxes[3:0]];
   assign sum  = {1'b0, op_a} + {1'b0, op_b};
   assign diff = {1'b0, op_a} - {1'b0, op_b};

   always_comb begin
      res        = '0;
      flags_nxt  = flags_q;
      does_write = 1'b0;
      if (legal) begin
         case (code)
            OP_ADD: begin
               res           = sum[WIDTH-1:0];
               does_write    = 1'b1;
               flags_nxt[FC] = sum[WIDTH];
               flags_nxt[FF] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                               (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
               res           = diff[WIDTH-1:0];
               does_write    = 1'b1;
               flags_nxt[FC] = diff[WIDTH];
               flags_nxt[FF] = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                               (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_CMP: begin
               flags_nxt[FZ] = (op_a == op_b);
               flags_nxt[FL] = diff[WIDTH];
               flags_nxt[FN] = ($signed(op_a) < $signed(op_b));
            end
            OP_AND: begin
               res        = op_a & op_b;
               does_write = 1'b1;
            end
            OP_OR: begin
               res        = op_a | op_b;
               does_write = 1'b1;
            end
            OP_XOR: begin
               res        = op_a ^ op_b;
               does_write = 1'b1;
            end
            OP_MOV: begin
               res        = op_b;
               does_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         last_q    <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= ~legal;
         if (legal) flags_q <= flags_nxt;
         if (does_write) begin
            for (int i = 0; i < NREGS; i++) begin
               if (cw.regs_en[i]) regs[i] <= res;
            end
            if (|cw.regs_en) last_q <= res;
         end
      end
   end

   assign cw.disp_data   = regs[cw.disp_sel];
   assign cw.result      = res;
   assign cw.last_result = last_q;
   assign cw.flags       = flags_q;
   assign cw.illegal_op  = illegal_q;

endmodule
